// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM state encoding and frame geometry.
package uart_boot_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LEN_BYTES  = 2;
  localparam int CPU_WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

endpackage

// File: rtl/uart_gap_timer.sv
// Saturating inter-byte gap counter; expired holds once TIMEOUT_CLKS-1 idle clocks have passed.
module uart_gap_timer #(
  parameter int TIMEOUT_CLKS = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/uart_boot_loader.sv
// Turns a UART byte stream (16-bit word count, then big-endian words) into memory writes,
// holding the CPU in reset until a frame completes cleanly.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int TIMEOUT_CLKS = 2_000_000
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Start,
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  output logic                  o_Mem_We,
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  output logic [CPU_WORD_W-1:0] o_Mem_Wdata,
  output logic                  o_Cpu_Reset,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Err
);

  localparam int BYTE_IDX_W = $clog2(WORD_BYTES);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(WORD_BYTES - 1);
  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

  state_t                  state, state_nxt;
  logic [LEN_BYTES*8-1:0]  word_count;
  logic [LEN_BYTES*8-1:0]  len_full;
  logic [ADDR_WIDTH:0]     word_idx;
  logic [BYTE_IDX_W-1:0]   byte_idx;
  logic [CPU_WORD_W-9:0]   shift_word;
  logic [CPU_WORD_W-1:0]   next_word;
  logic [CPU_WORD_W-1:0]   mem_wdata;
  logic                    mem_we;
  logic                    in_frame;
  logic                    gap_clear;
  logic                    gap_expired;
  logic                    word_complete;
  logic                    last_word;

  assign in_frame      = (state == ST_LEN_LO) || (state == ST_DATA);
  assign gap_clear     = i_Rx_DV || !in_frame;
  assign len_full      = {word_count[15:8], i_Rx_Byte};
  assign next_word     = {shift_word, i_Rx_Byte};
  assign word_complete = i_Rx_DV && (state == ST_DATA) && (byte_idx == LAST_BYTE);
  // The index is one bit wider than the address so a full-capacity count compares without wrap.
  assign last_word     = (32'(word_idx) + 32'd1) == 32'(word_count);

  uart_gap_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_gap_timer (
    .clk    (i_Clock),
    .rst    (i_Reset),
    .clear  (gap_clear),
    .enable (in_frame),
    .expired(gap_expired)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (i_Start) state_nxt = ST_ARMED;
      ST_ARMED:                 if (i_Rx_DV) state_nxt = ST_LEN_LO;
      ST_LEN_LO: begin
        if (i_Rx_DV) begin
          if (len_full == '0)                   state_nxt = ST_DONE;
          else if (32'(len_full) > CAPACITY)    state_nxt = ST_ERR;
          else                                  state_nxt = ST_DATA;
        end else if (gap_expired) begin
          state_nxt = ST_ERR;
        end
      end
      ST_DATA: begin
        if (i_Rx_DV) begin
          if (word_complete && last_word) state_nxt = ST_DONE;
        end else if (gap_expired) begin
          state_nxt = ST_ERR;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      word_count <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      shift_word <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      // The address advances after the strobe cycle; a new Start below overrides it.
      if (mem_we) word_idx <= word_idx + (ADDR_WIDTH + 1)'(1);
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: if (i_Start) word_idx <= '0;
        ST_ARMED:  if (i_Rx_DV) word_count[15:8] <= i_Rx_Byte;
        ST_LEN_LO: if (i_Rx_DV) begin
          word_count[7:0] <= i_Rx_Byte;
          byte_idx        <= '0;
        end
        ST_DATA: if (i_Rx_DV) begin
          shift_word <= next_word[CPU_WORD_W-9:0];
          byte_idx   <= byte_idx + BYTE_IDX_W'(1);
          if (byte_idx == LAST_BYTE) begin
            mem_we    <= 1'b1;
            mem_wdata <= next_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Mem_We    = mem_we;
  assign o_Mem_Addr  = word_idx[ADDR_WIDTH-1:0];
  assign o_Mem_Wdata = mem_wdata;
  assign o_Cpu_Reset = (state != ST_DONE);
  assign o_Busy      = in_frame || (state == ST_ARMED);
  assign o_Done      = (state == ST_DONE);
  assign o_Err       = (state == ST_ERR);

endmodule
